// File: rtl/audio_looper_ovd_pkg.sv
// rtl/audio_looper_ovd_pkg.sv - looper_pkg: FSM state encoding and sample mix helpers
package looper_pkg;

  typedef enum logic [2:0] {
    EMPTY   = 3'd0,
    RECORD  = 3'd1,
    IDLE    = 3'd2,
    PLAY    = 3'd3,
    OVERDUB = 3'd4
  } looper_state_t;

  // Signed sum clamped to the range of a width-bit two's complement value
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int width);
    logic signed [63:0] sum, hi, lo;
    sum = a + b;
    hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (width - 1));
    if (sum > hi)      return hi;
    else if (sum < lo) return lo;
    else               return sum;
  endfunction

  // Arithmetic average; the wide sum cannot overflow for any sample width
  function automatic logic signed [63:0] avg_mix(input logic signed [63:0] a,
                                                 input logic signed [63:0] b);
    return (a + b) >>> 1;
  endfunction

endpackage

// File: rtl/audio_looper_ovd_if.sv
// rtl/audio_looper_ovd_if.sv - looper sample/command bus with master (source) and slave (looper) views
interface audio_looper_ovd_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 16
);
  logic                     sample_en;
  logic signed [DATA_W-1:0] in_data;
  logic                     rec;
  logic                     play;
  logic                     ovd;
  logic                     reverse;
  logic                     clear;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic [ADDR_W:0]          loop_len;
  logic [2:0]               state;
  logic [ADDR_W-1:0]        position;

  modport master (
    output sample_en, in_data, rec, play, ovd, reverse, clear,
    input  out_data, out_valid, loop_len, state, position
  );

  modport slave (
    input  sample_en, in_data, rec, play, ovd, reverse, clear,
    output out_data, out_valid, loop_len, state, position
  );
endinterface

// File: rtl/audio_looper_ovd_ram.sv
// rtl/audio_looper_ovd_ram.sv - looper_ram: single-port loop memory, registered read, write enable
module looper_ram #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

  // read-first single port; contents are never reset
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/audio_looper_ovd.sv
// rtl/audio_looper_ovd.sv - strobe-driven loop recorder/player with overdub; LOOPER_SAT_MIX_EN selects saturating mix over averaging
module audio_looper_ovd
  import looper_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  audio_looper_ovd_if.slave bus
);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  looper_state_t            st, act, s1_mode;
  logic [ADDR_W-1:0]        pos, act_addr, last_addr, s1_addr, ram_addr;
  logic [ADDR_W:0]          len;
  logic                     rec_hold, rec_eff, s1_valid, ram_we, out_valid;
  logic signed [DATA_W-1:0] s1_in, ram_rdata, ram_wdata, mix, out_data;

  // after an auto-stop, rec must be released before a new take can start
  assign rec_eff   = bus.rec & ~rec_hold;
  // a full loop has len low bits of zero, so this wraps to the top address
  assign last_addr = len[ADDR_W-1:0] - 1'b1;

  // action and RAM address for the current strobe; transitions act immediately
  always_comb begin
    act      = st;
    act_addr = pos;
    if (bus.clear) begin
      act      = EMPTY;
      act_addr = '0;
    end else if (rec_eff) begin
      act      = RECORD;
      act_addr = (st == RECORD) ? pos + 1'b1 : '0;
    end else begin
      case (st)
        EMPTY: begin
          act      = EMPTY;
          act_addr = '0;
        end
        RECORD: begin
          act      = IDLE;
          act_addr = '0;
        end
        IDLE: begin
          if (bus.ovd || bus.play) begin
            act      = bus.ovd ? OVERDUB : PLAY;
            act_addr = bus.reverse ? last_addr : '0;
          end else begin
            act      = IDLE;
            act_addr = '0;
          end
        end
        PLAY, OVERDUB: begin
          act = bus.ovd ? OVERDUB : (bus.play ? PLAY : IDLE);
          if (act == IDLE)       act_addr = '0;
          else if (bus.reverse)  act_addr = (pos == '0) ? last_addr : pos - 1'b1;
          else                   act_addr = (pos == last_addr) ? '0 : pos + 1'b1;
        end
        default: begin
          act      = EMPTY;
          act_addr = '0;
        end
      endcase
    end
  end

  // looper FSM: state, position and loop length only change on strobe edges
  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= EMPTY;
      pos      <= '0;
      len      <= '0;
      rec_hold <= 1'b0;
    end else if (bus.sample_en) begin
      rec_hold <= rec_hold & bus.rec;
      case (act)
        EMPTY: begin
          st  <= EMPTY;
          pos <= '0;
          len <= '0;
        end
        RECORD: begin
          if (act_addr == ADDR_MAX) begin
            st       <= IDLE;
            pos      <= '0;
            len      <= {1'b1, {ADDR_W{1'b0}}};
            rec_hold <= 1'b1;
          end else begin
            st  <= RECORD;
            pos <= act_addr;
          end
        end
        IDLE: begin
          st  <= IDLE;
          pos <= '0;
          if (st == RECORD) len <= {1'b0, pos} + 1'b1;
        end
        default: begin
          st  <= act;
          pos <= act_addr;
        end
      endcase
    end
  end

`ifdef LOOPER_SAT_MIX_EN
  assign mix = DATA_W'(sat_add(64'(ram_rdata), 64'(s1_in), DATA_W));
`else
  assign mix = DATA_W'(avg_mix(64'(ram_rdata), 64'(s1_in)));
`endif

  // the RAM port reads on the strobe cycle and writes back on the following cycle
  assign ram_we    = s1_valid && (s1_mode == RECORD || s1_mode == OVERDUB);
  assign ram_addr  = s1_valid ? s1_addr : act_addr;
  assign ram_wdata = (s1_mode == OVERDUB) ? mix : s1_in;

  looper_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // two-stage strobe pipeline: capture the action, then register the output sample
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_mode   <= EMPTY;
      s1_addr   <= '0;
      s1_in     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      s1_valid <= bus.sample_en;
      if (bus.sample_en) begin
        s1_mode <= act;
        s1_addr <= act_addr;
        s1_in   <= bus.in_data;
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        case (s1_mode)
          PLAY:    out_data <= ram_rdata;
          OVERDUB: out_data <= mix;
          default: out_data <= s1_in;
        endcase
      end
    end
  end

  assign bus.out_data  = out_data;
  assign bus.out_valid = out_valid;
  assign bus.loop_len  = len;
  assign bus.state     = st;
  assign bus.position  = pos;

endmodule

// File: tb/tb_audio_looper_ovd.sv
// tb/tb_audio_looper_ovd.sv - scoreboard bench for audio_looper_ovd at ADDR_W=3
module tb_audio_looper_ovd;
  localparam int DW = 24;
  localparam int AW = 3;
  localparam logic [2:0] S_EMPTY = 3'd0, S_RECORD = 3'd1, S_IDLE = 3'd2, S_PLAY = 3'd3, S_OVD = 3'd4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  audio_looper_ovd_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  audio_looper_ovd #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;
  logic signed [DW-1:0] exp_q[$];
  logic signed [DW-1:0] mem[8];
  logic signed [DW-1:0] m;
  int rev_order[4] = '{1, 0, 4, 3};
  int corner[3]    = '{32'h007FFFFF, 100, -8388608};
  int ov_in[3]     = '{1, 50, -1};
  int rev_start[4] = '{2, 1, 0, 2};

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // reference mix, built from a DW+1 bit sum
  function automatic logic signed [DW-1:0] mixf(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    logic signed [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
`ifdef LOOPER_SAT_MIX_EN
    if (s[DW] != s[DW-1]) return s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    return s[DW-1:0];
`else
    return s[DW:1];
`endif
  endfunction

  task automatic strobe(input int din, input int r, input int p, input int o, input int rv, input int c, input int want);
    @(negedge clk);
    bus.sample_en = 1'b1;
    bus.in_data   = DW'(din);
    bus.rec       = (r != 0);
    bus.play      = (p != 0);
    bus.ovd       = (o != 0);
    bus.reverse   = (rv != 0);
    bus.clear     = (c != 0);
    exp_q.push_back(DW'(want));
    @(negedge clk);
    bus.sample_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_out", exp_q.size(), 1);
      else chk("out_data", bus.out_data, exp_q.pop_front());
    end
  end

  int cyc = 0;
  int last_se = -10;
  always @(posedge clk) begin
    cyc++;
    if (bus.sample_en) begin
      assert (cyc - last_se >= 3) else $error("strobe spacing below 3 cycles");
      last_se = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.sample_en = 1'b0; bus.in_data = '0; bus.rec = 1'b0; bus.play = 1'b0;
    bus.ovd = 1'b0; bus.reverse = 1'b0; bus.clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", bus.state, S_EMPTY);
    chk("rst_position", bus.position, 0);
    chk("rst_loop_len", bus.loop_len, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    reset = 1'b0;

    strobe(7, 0, 1, 1, 0, 0, 7);
    chk("empty_ignores_play_ovd", bus.state, S_EMPTY);
    strobe(-3, 0, 1, 0, 0, 0, -3);
    chk("empty_ignores_play", bus.state, S_EMPTY);

    for (int i = 0; i < 5; i++) begin
      strobe(10 + i, 1, 0, 0, 0, 0, 10 + i);
      mem[i] = DW'(10 + i);
      chk("rec_state", bus.state, S_RECORD);
    end
    strobe(99, 0, 0, 0, 0, 0, 99);
    chk("rec_stop_len", bus.loop_len, 5);
    chk("rec_stop_state", bus.state, S_IDLE);
    chk("rec_stop_pos", bus.position, 0);

    for (int i = 0; i < 8; i++) strobe(0, 0, 1, 0, 0, 0, int'(mem[i % 5]));
    chk("play_state", bus.state, S_PLAY);
    chk("play_pos", bus.position, 2);
    for (int i = 0; i < 4; i++) strobe(0, 0, 1, 0, 1, 0, int'(mem[rev_order[i]]));
    chk("rev_pos", bus.position, 3);
    strobe(5, 0, 0, 0, 0, 0, 5);
    chk("play_stop_state", bus.state, S_IDLE);
    chk("play_stop_pos", bus.position, 0);

    for (int i = 0; i < 5; i++) begin
      m = mixf(mem[i], DW'(1));
      strobe(1, 0, 0, 1, 0, 0, int'(m));
      mem[i] = m;
    end
    chk("ovd_state", bus.state, S_OVD);
    for (int i = 0; i < 5; i++) strobe(0, 0, 1, 0, 0, 0, int'(mem[i]));
    chk("ovd_to_play", bus.state, S_PLAY);

    strobe(42, 0, 1, 0, 0, 1, 42);
    chk("clear_state", bus.state, S_EMPTY);
    chk("clear_len", bus.loop_len, 0);

    for (int i = 0; i < 3; i++) begin
      strobe(corner[i], 1, 0, 0, 0, 0, corner[i]);
      mem[i] = DW'(corner[i]);
    end
    strobe(0, 0, 0, 0, 0, 0, 0);
    chk("corner_len", bus.loop_len, 3);
    for (int i = 0; i < 3; i++) begin
      m = mixf(mem[i], DW'(ov_in[i]));
      strobe(ov_in[i], 0, 0, 1, 0, 0, int'(m));
      mem[i] = m;
    end
    strobe(0, 0, 0, 0, 0, 0, 0);
    chk("ovd_to_idle", bus.state, S_IDLE);
    for (int i = 0; i < 4; i++) strobe(0, 0, 1, 0, 1, 0, int'(mem[rev_start[i]]));

    for (int i = 0; i < 9; i++) begin
      strobe(200 + i, 1, 0, 0, 0, 0, 200 + i);
      if (i < 8) mem[i] = DW'(200 + i);
      if (i == 0) chk("len_held_while_rec", bus.loop_len, 3);
      if (i == 7) chk("autostop_state", bus.state, S_IDLE);
    end
    chk("autostop_len", bus.loop_len, 8);
    chk("autostop_hold_state", bus.state, S_IDLE);
    for (int i = 0; i < 9; i++) strobe(0, 0, 1, 0, 0, 0, int'(mem[i % 8]));

    strobe(5, 1, 0, 0, 0, 0, 5);
    chk("rerec_state", bus.state, S_RECORD);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_state", bus.state, S_EMPTY);
    chk("midrst_out_data", bus.out_data, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_len", bus.loop_len, 0);
    reset = 1'b0;
    bus.rec = 1'b0;
    strobe(-9, 0, 0, 0, 0, 0, -9);
    chk("post_rst_state", bus.state, S_EMPTY);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
